ysyx_23060062_ifu: RTL
======================

YSYX_23060062_IFU -- requirements
Module: ysyx_23060062_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, PC loaded on reset SHALL be this value.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset SHALL be asynchronous and active-high.
REQ-004 imem_req  output  1  fetch request valid to instruction memory.
REQ-005 imem_addr  output  32  fetch address, SHALL equal current PC while imem_req=1.
REQ-006 imem_gnt  input  1  memory accepts request in the same cycle imem_req=1.
REQ-007 imem_rvalid  input  1  response valid; SHALL be treated as one-cycle pulse.
REQ-008 imem_rdata  input  32  fetched instruction, sampled when imem_rvalid=1.
REQ-009 inst_valid  output  1  instruction available to decoder.
REQ-010 inst  output  32  registered instruction word for decoder.
REQ-011 inst_pc  output  32  address of inst.
REQ-012 inst_ready  input  1  decoder consumes inst when inst_valid=1 and inst_ready=1.
REQ-013 redirect_valid  input  1  branch/jump/write-back PC update from execute stage.
REQ-014 redirect_pc  input  32  new PC; bits [1:0] SHALL be forced to 2'b00.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DRAIN; at most one request outstanding.
REQ-016 IDLE: imem_req=0; SHALL go to REQ on the first clock after reset release.
REQ-017 REQ: imem_req=1, imem_addr=pc; imem_gnt=1 SHALL move to WAIT, else stay REQ with address held stable.
REQ-018 WAIT: imem_rvalid=1 SHALL load inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, go HOLD.
REQ-019 HOLD: inst, inst_pc, inst_valid SHALL hold stable until inst_ready=1; then pc<=pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), inst_valid<=0, go REQ.
REQ-020 Minimum fetch latency: REQ with gnt in cycle N, rvalid in N+1 -> inst_valid=1 in N+2.
REQ-021 redirect_valid=1 SHALL take priority over every other event in the same cycle: pc<={redirect_pc[31:2],2'b00}, inst_valid<=0.
REQ-022 Redirect in IDLE, REQ (no gnt) or HOLD (with or without inst_ready): next state REQ; pc SHALL NOT increment.
REQ-023 Redirect in REQ with imem_gnt=1, or in WAIT without imem_rvalid: next state DRAIN (old response outstanding).
REQ-024 Redirect in WAIT with imem_rvalid=1: response discarded, next state REQ.
REQ-025 DRAIN: imem_req=0; imem_rvalid=1 SHALL be discarded (inst unchanged, inst_valid=0) and go REQ; redirect in DRAIN SHALL update pc and stay DRAIN unless rvalid also arrives, then go REQ.
REQ-026 inst_valid SHALL never assert for a response requested before the most recent redirect.
REQ-027 imem_rvalid in IDLE, REQ or HOLD is a protocol error and SHALL be ignored.

Reset
REQ-028 While rst=1: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=32'h0000_0013 (nop), inst_pc=RESET_PC.
REQ-029 Reset asserted mid-transaction SHALL abandon any outstanding request; a late imem_rvalid after release SHALL be ignored (arrives in IDLE/REQ).

Verification
REQ-030 Release rst, gnt=1 always, rvalid one cycle after gnt, rdata=32'h0010_0093, inst_ready=1 -> inst_valid pulse at cycle 3 with inst_pc=32'h8000_0000, next imem_addr=32'h8000_0004.
REQ-031 inst_ready=0 for 5 cycles in HOLD -> inst/inst_pc stable, imem_req=0, no pc increment; ready=1 -> next imem_addr = inst_pc+4.
REQ-032 redirect_valid=1, redirect_pc=32'h8000_0103 in WAIT, rvalid next cycle with rdata=32'hDEAD_BEEF -> response dropped, next imem_addr=32'h8000_0100, inst never equals 32'hDEAD_BEEF.
REQ-033 HOLD with inst_ready=1 and redirect_valid=1 (redirect_pc=32'h8000_0040) same cycle -> next imem_addr=32'h8000_0040, not inst_pc+4.
REQ-034 gnt held 0 for 4 cycles -> imem_req=1 and imem_addr constant throughout; pc=32'hFFFF_FFFC consumed -> next imem_addr=32'h0000_0000.
REQ-035 Assert rst asynchronously in WAIT, rvalid arrives 1 cycle after release -> outputs at REQ-028 values immediately, stale response ignored, first accepted fetch at RESET_PC.

Source files
------------

// File: rtl/ysyx_23060062_ifu_if.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060062_ifu_if
// Description : Bundle of the fetch-unit bus: instruction-memory request and
//               response, decoder hand-off, and execute-stage redirect.
// Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_23060062_ifu_if;
    // Instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    // Decoder side
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    // Execute-stage redirect
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Fetch unit drives requests and the decoder hand-off
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );

    // Memory / pipeline environment around the fetch unit
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready,
               redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_23060062_ifu.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060062_ifu
// Description : Instruction fetch unit. Issues one fetch at a time, holds the
//               returned word for the decoder, and honours execute-stage
//               redirects, draining any response already in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060062_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  wire                       clk,
    input  wire                       rst,
    ysyx_23060062_ifu_if.master       bus
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic        inst_valid_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;

    // Redirect target is word-aligned; the low two bits are simply dropped.
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;
    assign w_redirect_pc = bus.redirect_pc & ~32'h0000_0003;
    assign w_pc_inc      = pc_q + 32'd4;

    // The request address is the PC register itself, so it is stable while
    // the memory withholds its grant.
    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

    // Fetch FSM with registered outputs; redirect outranks every other event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= C_NOP;
            inst_pc_q    <= RESET_PC;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.redirect_valid) begin
                        pc_q <= w_redirect_pc;
                    end
                    inst_valid_q <= 1'b0;
                    state_q      <= S_REQ;
                    req_q        <= 1'b1;
                end
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        pc_q         <= w_redirect_pc;
                        inst_valid_q <= 1'b0;
                        // A granted request still owes us a response to discard.
                        if (bus.imem_gnt) begin
                            state_q <= S_DRAIN;
                            req_q   <= 1'b0;
                        end
                    end else if (bus.imem_gnt) begin
                        state_q <= S_WAIT;
                        req_q   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_q         <= w_redirect_pc;
                        inst_valid_q <= 1'b0;
                        if (bus.imem_rvalid) begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (bus.imem_rvalid) begin
                        inst_q       <= bus.imem_rdata;
                        inst_pc_q    <= pc_q;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.redirect_valid) begin
                        pc_q         <= w_redirect_pc;
                        inst_valid_q <= 1'b0;
                        state_q      <= S_REQ;
                        req_q        <= 1'b1;
                    end else if (bus.inst_ready) begin
                        pc_q         <= w_pc_inc;
                        inst_valid_q <= 1'b0;
                        state_q      <= S_REQ;
                        req_q        <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.redirect_valid) begin
                        pc_q <= w_redirect_pc;
                    end
                    inst_valid_q <= 1'b0;
                    // The stale response is dropped; only then may we re-issue.
                    if (bus.imem_rvalid) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_q        <= 1'b0;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
